pito_mvu_cmd_bridge: RTL and testbench

- Responder on the pito CSR write/read path. Pito firmware programs MVU job fields through CSRs and writes KICK; the bridge queues the job and issues it to the MVU over a valid/ready port.
- It then waits for MVU completion and raises an interrupt back to the hart until firmware acknowledges it.
- Sits inside barvinn between pito's CSR file and one MVU command port.

---
 rtl/pito_mvu_bridge_pkg.sv | 39 +++
 rtl/mvu_cmd_fifo.sv | 58 +++++
 rtl/pito_mvu_cmd_bridge.sv | 174 +++++++++++++++++
 tb/tb_pito_mvu_cmd_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pito_mvu_bridge_pkg.sv
// Shared types and constants for the pito -> MVU command bridge.
// Holds the packed MVU command layout, CSR offsets, FSM states and
// STATUS bit positions used by the bridge and its command FIFO.
package pito_mvu_bridge_pkg;

  // Packed command word sent to the MVU: wbase sits in the LSBs.
  typedef struct packed {
    logic [31:0] len;
    logic [31:0] obase;
    logic [31:0] ibase;
    logic [31:0] wbase;
  } mvu_cmd_t;

  // CSR offsets relative to CSR_BASE.
  localparam logic [11:0] OFF_WBASE   = 12'd0;
  localparam logic [11:0] OFF_IBASE   = 12'd1;
  localparam logic [11:0] OFF_OBASE   = 12'd2;
  localparam logic [11:0] OFF_LEN     = 12'd3;
  localparam logic [11:0] OFF_KICK    = 12'd4;
  localparam logic [11:0] OFF_IRQ_ACK = 12'd5;
  localparam logic [11:0] OFF_STATUS  = 12'd6;

  // Bridge job-lifecycle states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    IRQ
  } state_t;

  // STATUS register bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_IRQ     = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_CNT_MSB = 4;
  localparam int STAT_OVF     = 5;
  localparam int STAT_TMO     = 6;

endpackage

// File: rtl/mvu_cmd_fifo.sv
// Synchronous FIFO holding queued MVU jobs.
// A push is accepted when not full, or when a pop happens in the same
// cycle; pointers wrap naturally because DEPTH is a power of two.
module mvu_cmd_fifo
  import pito_mvu_bridge_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pito_mvu_cmd_bridge.sv
// CSR-programmed command bridge between pito and one MVU command port.
// Firmware stages job fields, KICKs them into a FIFO, and the bridge
// issues each job, waits for completion and holds an irq until acked.
// Optional watchdog: define PITO_MVU_BRIDGE_TIMEOUT_EN to bound WAIT_DONE.
module pito_mvu_cmd_bridge
  import pito_mvu_bridge_pkg::*;
#(
  parameter logic [11:0] CSR_BASE       = 12'hF20,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         csr_we,
  input  logic [11:0]  csr_waddr,
  input  logic [31:0]  csr_wdata,
  input  logic         csr_re,
  input  logic [11:0]  csr_raddr,
  output logic [31:0]  csr_rdata,
  output logic         mvu_cmd_valid,
  input  logic         mvu_cmd_ready,
  output logic [127:0] mvu_cmd,
  input  logic         mvu_done,
  output logic         mvu_irq
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  mvu_cmd_t        staging_q;
  mvu_cmd_t        cmd_q;
  mvu_cmd_t        fifo_rdata;
  state_t          state_q;
  state_t          state_d;
  logic            overflow_q;
  logic            timeout_q;
  logic            timeout_evt;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [2:0]      count3;
  logic            pop;
  logic            kick;
  logic            ack;
  logic            we_status;
  logic            overflow_evt;
  logic [31:0]     status_word;
  logic [31:0]     rd_val;

  assign kick         = csr_we && (csr_waddr == CSR_BASE + OFF_KICK);
  assign ack          = csr_we && (csr_waddr == CSR_BASE + OFF_IRQ_ACK) && csr_wdata[0];
  assign we_status    = csr_we && (csr_waddr == CSR_BASE + OFF_STATUS);
  assign pop          = (state_q == IDLE) && !fifo_empty;
  assign overflow_evt = kick && fifo_full && !pop;

  mvu_cmd_fifo #(
    .WIDTH (128),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kick),
    .wdata (staging_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef PITO_MVU_BRIDGE_TIMEOUT_EN
  logic [31:0] wd_cnt_q;

  // Watchdog counts cycles spent in WAIT_DONE, restarting on each entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == ISSUE && state_d == WAIT_DONE) begin
      wd_cnt_q <= '0;
    end else if (state_q == WAIT_DONE) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic for the job lifecycle.
  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    unique case (state_q)
      IDLE:      if (!fifo_empty) state_d = ISSUE;
      ISSUE:     if (mvu_cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (mvu_done) begin
          state_d = IRQ;
        end
`ifdef PITO_MVU_BRIDGE_TIMEOUT_EN
        else if (wd_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IRQ;
          timeout_evt = 1'b1;
        end
`endif
      end
      IRQ:       if (ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register and the command latched on each FIFO pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= fifo_rdata;
    end
  end

  // Staging registers written by firmware before a KICK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
    end else if (csr_we) begin
      if (csr_waddr == CSR_BASE + OFF_WBASE) staging_q.wbase <= csr_wdata;
      if (csr_waddr == CSR_BASE + OFF_IBASE) staging_q.ibase <= csr_wdata;
      if (csr_waddr == CSR_BASE + OFF_OBASE) staging_q.obase <= csr_wdata;
      if (csr_waddr == CSR_BASE + OFF_LEN)   staging_q.len   <= csr_wdata;
    end
  end

  // Sticky error flags; a new event in the clearing cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (we_status)    overflow_q <= 1'b0;
      if (we_status)    timeout_q  <= 1'b0;
      if (overflow_evt) overflow_q <= 1'b1;
      if (timeout_evt)  timeout_q  <= 1'b1;
    end
  end

  assign count3      = 3'(fifo_count);
  assign status_word = {25'd0, timeout_q, overflow_q, count3,
                        (state_q == IRQ), (state_q != IDLE)};

  // Read-address decode; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    if (csr_raddr == CSR_BASE + OFF_WBASE)       rd_val = staging_q.wbase;
    else if (csr_raddr == CSR_BASE + OFF_IBASE)  rd_val = staging_q.ibase;
    else if (csr_raddr == CSR_BASE + OFF_OBASE)  rd_val = staging_q.obase;
    else if (csr_raddr == CSR_BASE + OFF_LEN)    rd_val = staging_q.len;
    else if (csr_raddr == CSR_BASE + OFF_STATUS) rd_val = status_word;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata <= '0;
    end else if (csr_re) begin
      csr_rdata <= rd_val;
    end
  end

  assign mvu_cmd_valid = (state_q == ISSUE);
  assign mvu_cmd       = cmd_q;
  assign mvu_irq       = (state_q == IRQ);

endmodule

// File: tb/tb_pito_mvu_cmd_bridge.sv
// Directed self-checking bench for pito_mvu_cmd_bridge.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pito_mvu_cmd_bridge;

  localparam logic [11:0] BASE   = 12'hF20;
  localparam logic [11:0] WBASE  = BASE + 12'd0;
  localparam logic [11:0] IBASE  = BASE + 12'd1;
  localparam logic [11:0] OBASE  = BASE + 12'd2;
  localparam logic [11:0] LEN    = BASE + 12'd3;
  localparam logic [11:0] KICK   = BASE + 12'd4;
  localparam logic [11:0] ACK    = BASE + 12'd5;
  localparam logic [11:0] STATUS = BASE + 12'd6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         csr_we;
  logic [11:0]  csr_waddr;
  logic [31:0]  csr_wdata;
  logic         csr_re;
  logic [11:0]  csr_raddr;
  logic [31:0]  csr_rdata;
  logic         mvu_cmd_valid;
  logic         mvu_cmd_ready;
  logic [127:0] mvu_cmd;
  logic         mvu_done;
  logic         mvu_irq;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pito_mvu_cmd_bridge #(
    .CSR_BASE       (BASE),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .csr_re        (csr_re),
    .csr_raddr     (csr_raddr),
    .csr_rdata     (csr_rdata),
    .mvu_cmd_valid (mvu_cmd_valid),
    .mvu_cmd_ready (mvu_cmd_ready),
    .mvu_cmd       (mvu_cmd),
    .mvu_done      (mvu_done),
    .mvu_irq       (mvu_irq)
  );

  function automatic logic [127:0] mk_cmd(input logic [31:0] len);
    return {len, 32'h300, 32'h200, 32'h100};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_waddr = addr;
    csr_wdata = data;
    @(negedge clk);
    csr_we    = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    csr_re    = 1'b1;
    csr_raddr = addr;
    @(negedge clk);
    csr_re    = 1'b0;
    data      = csr_rdata;
  endtask

  task automatic pulse_done();
    mvu_done = 1'b1;
    @(negedge clk);
    mvu_done = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mvu_cmd_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(tag, 128'(seen), 128'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          n;

    rst_n = 1'b0;
    csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
    csr_re = 1'b0; csr_raddr = '0;
    mvu_cmd_ready = 1'b1;
    mvu_done = 1'b0;

    #12;
    checkOutput("reset_valid", 128'(mvu_cmd_valid), 128'd0);
    checkOutput("reset_cmd", mvu_cmd, 128'd0);
    checkOutput("reset_irq", 128'(mvu_irq), 128'd0);
    checkOutput("reset_rdata", 128'(csr_rdata), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job with ready high.
    csr_write(WBASE, 32'h100);
    csr_write(IBASE, 32'h200);
    csr_write(OBASE, 32'h300);
    csr_write(LEN,   32'h40);
    csr_read(WBASE, rd);  checkOutput("rd_wbase", 128'(rd), 128'h100);
    csr_read(LEN, rd);    checkOutput("rd_len", 128'(rd), 128'h40);
    csr_write(KICK, 32'h0);
    checkOutput("latency_early", 128'(mvu_cmd_valid), 128'd0);
    @(negedge clk);
    checkOutput("latency_valid", 128'(mvu_cmd_valid), 128'd1);
    checkOutput("job_cmd", mvu_cmd, mk_cmd(32'h40));
    @(negedge clk);
    checkOutput("valid_one_cycle", 128'(mvu_cmd_valid), 128'd0);
    csr_read(STATUS, rd); checkOutput("status_wait", 128'(rd), 128'h1);
    csr_write(ACK, 32'h1);
    pulse_done();
    checkOutput("irq_raised", 128'(mvu_irq), 128'd1);
    csr_read(STATUS, rd); checkOutput("status_irq", 128'(rd), 128'h3);
    csr_write(ACK, 32'h0);
    checkOutput("ack_bit0_zero", 128'(mvu_irq), 128'd1);
    csr_write(ACK, 32'h1);
    checkOutput("irq_cleared", 128'(mvu_irq), 128'd0);
    csr_read(STATUS, rd); checkOutput("status_idle", 128'(rd), 128'h0);
    csr_read(WBASE, rd);  checkOutput("staging_kept", 128'(rd), 128'h100);

    // Six jobs with ready low: one issues, four queue, the sixth drops.
    mvu_cmd_ready = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      csr_write(LEN, 32'(j));
      csr_write(KICK, 32'h0);
    end
    csr_read(STATUS, rd); checkOutput("status_full_ovf", 128'(rd), 128'h31);
    checkOutput("issue_job1", mvu_cmd, mk_cmd(32'd1));
    for (int i = 0; i < 5; i++) begin
      mvu_done = (i == 2);
      @(negedge clk);
      checkOutput("hold_valid", 128'(mvu_cmd_valid), 128'd1);
      checkOutput("hold_cmd", mvu_cmd, mk_cmd(32'd1));
    end
    mvu_done = 1'b0;
    csr_write(STATUS, 32'hFFFF_FFFF);
    csr_read(STATUS, rd); checkOutput("status_ovf_clr", 128'(rd), 128'h11);
    mvu_cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("handshake_job1", 128'(mvu_cmd_valid), 128'd0);
    pulse_done();
    checkOutput("irq_job1", 128'(mvu_irq), 128'd1);

    // KICK in the same cycle the full FIFO pops is accepted.
    mvu_cmd_ready = 1'b0;
    csr_write(ACK, 32'h1);
    csr_write(KICK, 32'h0);
    csr_read(STATUS, rd); checkOutput("status_kick_on_pop", 128'(rd), 128'h11);
    checkOutput("issue_job2", mvu_cmd, mk_cmd(32'd2));
    mvu_cmd_ready = 1'b1;
    @(negedge clk);
    pulse_done();
    checkOutput("irq_job2", 128'(mvu_irq), 128'd1);
    csr_write(ACK, 32'h1);
    for (int j = 3; j <= 6; j++) begin
      wait_valid("valid_queued");
      checkOutput("queued_cmd", mvu_cmd, mk_cmd(32'(j)));
      @(negedge clk);
      pulse_done();
      checkOutput("queued_irq", 128'(mvu_irq), 128'd1);
      csr_write(ACK, 32'h1);
    end
    csr_read(STATUS, rd); checkOutput("status_drained", 128'(rd), 128'h0);

    // Unmapped address.
    csr_write(BASE + 12'd7, 32'hDEAD_BEEF);
    csr_read(BASE + 12'd7, rd); checkOutput("unmapped_read", 128'(rd), 128'h0);

    // Reset while waiting for completion.
    csr_write(KICK, 32'h0);
    @(negedge clk);
    @(negedge clk);
    csr_read(WBASE, rd); checkOutput("pre_reset_rd", 128'(rd), 128'h100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 128'(mvu_cmd_valid), 128'd0);
    checkOutput("async_rst_cmd", mvu_cmd, 128'd0);
    checkOutput("async_rst_irq", 128'(mvu_irq), 128'd0);
    checkOutput("async_rst_rdata", 128'(csr_rdata), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    csr_read(STATUS, rd); checkOutput("post_rst_status", 128'(rd), 128'h0);
    pulse_done();
    checkOutput("post_rst_no_irq", 128'(mvu_irq), 128'd0);
    csr_read(WBASE, rd); checkOutput("post_rst_wbase", 128'(rd), 128'h0);

`ifdef PITO_MVU_BRIDGE_TIMEOUT_EN
    // Watchdog: no completion, irq after 10 cycles in WAIT_DONE.
    csr_write(KICK, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n = 0;
    while (!mvu_irq && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", 128'(n), 128'd10);
    csr_read(STATUS, rd); checkOutput("status_timeout", 128'(rd), 128'h43);
    csr_write(ACK, 32'h1);
    csr_write(STATUS, 32'h0);
    csr_read(STATUS, rd); checkOutput("status_tmo_clr", 128'(rd), 128'h0);
`else
    n = 0;
    csr_read(STATUS, rd); checkOutput("status_final", 128'(rd), 128'(n));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
